// File: rtl/wb_conv1d_engine.sv
// wb_conv1d_engine: Wishbone-slave 1-D convolution engine.
// Samples are pushed into an input FIFO and shifted through a TAPS-deep window.
// Once the window holds TAPS samples, one output per sample is computed by a
// sequential MAC (one tap per cycle) and queued in an output FIFO for the bus.
module wb_conv1d_engine #(
    parameter int DW        = 8,
    parameter int TAPS      = 3,
    parameter int IN_DEPTH  = 4,
    parameter int OUT_DEPTH = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        busy_flag,
    output logic        in_full_flag,
    output logic        out_valid_flag,
    output logic        err_flag,
    output logic        irq_o
);

    localparam int AW  = 2*DW + $clog2(TAPS);
    localparam int IAW = $clog2(IN_DEPTH);
    localparam int OAW = $clog2(OUT_DEPTH);
    localparam int ICW = IAW + 1;
    localparam int OCW = OAW + 1;
    localparam int TW  = $clog2(TAPS);
    localparam int WCW = $clog2(TAPS + 1);

    localparam logic [7:0]     WT_LAST    = 8'(16 + TAPS - 1);
    localparam logic [TW-1:0]  TAP_LAST   = TW'(TAPS - 1);
    localparam logic [WCW-1:0] WARM_FULL  = WCW'(TAPS);
    localparam logic [WCW-1:0] WARM_LAST  = WCW'(TAPS - 1);
    localparam logic [ICW-1:0] IN_FULLC   = ICW'(IN_DEPTH);
    localparam logic [OCW-1:0] OUT_FULLC  = OCW'(OUT_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_MAC, S_WRITE} state_t;

    // ---------------- registers ----------------
    logic                 r_ack;
    logic [31:0]          r_dat;
    logic                 r_en;
    logic                 r_irq_en;
    logic                 r_ovf;
    logic                 r_unf;
    logic                 r_cfg_err;
    logic signed [DW-1:0] r_w [TAPS];
    logic signed [DW-1:0] r_x [TAPS];
    logic signed [AW-1:0] r_acc;
    logic [TW-1:0]        r_tap;
    logic [WCW-1:0]       r_warm;
    state_t               r_state;

    logic signed [DW-1:0] r_in_mem [IN_DEPTH];
    logic [IAW-1:0]       r_in_wp;
    logic [IAW-1:0]       r_in_rp;
    logic [ICW-1:0]       r_in_cnt;

    logic signed [AW-1:0] r_out_mem [OUT_DEPTH];
    logic [OAW-1:0]       r_out_wp;
    logic [OAW-1:0]       r_out_rp;
    logic [OCW-1:0]       r_out_cnt;

    // ---------------- wires ----------------
    logic                 w_req;
    logic                 w_wr;
    logic                 w_rd;
    logic [7:0]           w_idx;
    logic                 w_wt_hit;
    logic [TW-1:0]        w_wt_idx;
    logic                 w_wr_ctrl;
    logic                 w_clr;
    logic                 w_wr_din;
    logic                 w_rd_dout;
    logic                 w_wr_wt;
    logic                 w_in_full;
    logic                 w_in_empty;
    logic                 w_out_full;
    logic                 w_out_empty;
    logic                 w_in_push;
    logic                 w_in_pop;
    logic                 w_out_push;
    logic                 w_out_pop;
    logic                 w_eng_push;
    logic                 w_busy;
    logic signed [AW-1:0] w_prod;
    logic [31:0]          w_status;
    logic [31:0]          w_rdata;
    state_t               w_state_nxt;
    logic                 w_unused;

    // Byte selects and the address bits outside the index field carry no meaning here.
    assign w_unused = ^{wbs_sel_i, wbs_adr_i, wbs_dat_i};

    // ---------------- bus decode ----------------
    // A request is taken only while ack is low, which yields the one-cycle ack
    // followed by a mandatory idle cycle.
    assign w_req     = wbs_stb_i & wbs_cyc_i & ~r_ack;
    assign w_wr      = w_req &  wbs_we_i;
    assign w_rd      = w_req & ~wbs_we_i;
    assign w_idx     = wbs_adr_i[23:16];
    assign w_wt_hit  = (w_idx >= 8'h10) && (w_idx <= WT_LAST);
    assign w_wt_idx  = TW'(w_idx - 8'h10);
    assign w_wr_ctrl = w_wr && (w_idx == 8'h00);
    assign w_clr     = w_wr_ctrl & wbs_dat_i[1];
    assign w_wr_din  = w_wr && (w_idx == 8'h02);
    assign w_rd_dout = w_rd && (w_idx == 8'h03);
    assign w_wr_wt   = w_wr && w_wt_hit;

    assign w_in_full   = (r_in_cnt == IN_FULLC);
    assign w_in_empty  = (r_in_cnt == '0);
    assign w_out_full  = (r_out_cnt == OUT_FULLC);
    assign w_out_empty = (r_out_cnt == '0);

    assign w_in_push  = w_wr_din & ~w_in_full;
    assign w_out_pop  = w_rd_dout & ~w_out_empty;
    assign w_out_push = w_eng_push & ~w_out_full;

    assign w_prod = AW'(r_w[r_tap]) * AW'(r_x[r_tap]);

    assign w_status = {8'(r_in_cnt), 8'(r_out_cnt), 11'b0,
                       r_ovf, r_unf, r_cfg_err, ~w_out_empty, w_busy};

    // Read-data mux; results are sign-extended, weights zero-extended.
    always_comb begin
        w_rdata = '0;
        case (w_idx)
            8'h00:   w_rdata = {29'b0, r_irq_en, 1'b0, r_en};
            8'h01:   w_rdata = w_status;
            8'h03:   if (!w_out_empty) w_rdata = 32'(r_out_mem[r_out_rp]);
            default: if (w_wt_hit) w_rdata = 32'($unsigned(r_w[w_wt_idx]));
        endcase
    end

    // Bus response: ack and read data registered, data zero outside read acks.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_ack <= 1'b0;
            r_dat <= '0;
        end else begin
            r_ack <= w_req;
            r_dat <= w_rd ? w_rdata : '0;
        end
    end

    // Control, sticky error bits and weight storage.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_en      <= 1'b0;
            r_irq_en  <= 1'b0;
            r_ovf     <= 1'b0;
            r_unf     <= 1'b0;
            r_cfg_err <= 1'b0;
            for (int k = 0; k < TAPS; k++) r_w[k] <= '0;
        end else begin
            if (w_wr_ctrl) begin
                r_en     <= wbs_dat_i[0];
                r_irq_en <= wbs_dat_i[2];
            end
            if (w_clr) begin
                r_ovf     <= 1'b0;
                r_unf     <= 1'b0;
                r_cfg_err <= 1'b0;
            end else begin
                if (w_wr_din  &  w_in_full)   r_ovf     <= 1'b1;
                if (w_rd_dout &  w_out_empty) r_unf     <= 1'b1;
                if (w_wr_wt   &  w_busy)      r_cfg_err <= 1'b1;
            end
            if (w_wr_wt & ~w_busy) r_w[w_wt_idx] <= wbs_dat_i[DW-1:0];
        end
    end

    // ---------------- input FIFO ----------------
    // Input FIFO storage; contents need no reset, validity lives in the count.
    always_ff @(posedge wb_clk_i) begin
        if (w_in_push) r_in_mem[r_in_wp] <= wbs_dat_i[DW-1:0];
    end

    // Input FIFO pointers; bus push and engine pop may land together.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_in_wp  <= '0;
            r_in_rp  <= '0;
            r_in_cnt <= '0;
        end else if (w_clr) begin
            r_in_wp  <= '0;
            r_in_rp  <= '0;
            r_in_cnt <= '0;
        end else begin
            if (w_in_push) r_in_wp <= r_in_wp + IAW'(1);
            if (w_in_pop)  r_in_rp <= r_in_rp + IAW'(1);
            case ({w_in_push, w_in_pop})
                2'b10:   r_in_cnt <= r_in_cnt + ICW'(1);
                2'b01:   r_in_cnt <= r_in_cnt - ICW'(1);
                default: ;
            endcase
        end
    end

    // ---------------- output FIFO ----------------
    // Output FIFO storage for finished results.
    always_ff @(posedge wb_clk_i) begin
        if (w_out_push) r_out_mem[r_out_wp] <= r_acc;
    end

    // Output FIFO pointers; engine push and bus pop may land together.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_out_wp  <= '0;
            r_out_rp  <= '0;
            r_out_cnt <= '0;
        end else if (w_clr) begin
            r_out_wp  <= '0;
            r_out_rp  <= '0;
            r_out_cnt <= '0;
        end else begin
            if (w_out_push) r_out_wp <= r_out_wp + OAW'(1);
            if (w_out_pop)  r_out_rp <= r_out_rp + OAW'(1);
            case ({w_out_push, w_out_pop})
                2'b10:   r_out_cnt <= r_out_cnt + OCW'(1);
                2'b01:   r_out_cnt <= r_out_cnt - OCW'(1);
                default: ;
            endcase
        end
    end

    // ---------------- engine FSM ----------------
    // State register; CLR aborts any sample in flight.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)   r_state <= S_IDLE;
        else if (w_clr) r_state <= S_IDLE;
        else            r_state <= w_state_nxt;
    end

    // Next state. A sample that will not yet produce a result may start even
    // with the output FIFO full; one that will produce a result needs a free
    // slot, and only the engine fills that FIFO, so the slot is still there at WRITE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (r_en && !w_in_empty && (!w_out_full || (r_warm < WARM_LAST)))
                         w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = (r_warm >= WARM_LAST) ? S_MAC : S_IDLE;
            S_MAC:   if (r_tap == TAP_LAST) w_state_nxt = S_WRITE;
            S_WRITE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        w_busy     = (r_state != S_IDLE);
        w_in_pop   = (r_state == S_LOAD);
        w_eng_push = (r_state == S_WRITE);
    end

    // Window shift, warm-up tracking and the one-tap-per-cycle accumulator.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            for (int k = 0; k < TAPS; k++) r_x[k] <= '0;
            r_acc  <= '0;
            r_tap  <= '0;
            r_warm <= '0;
        end else if (w_clr) begin
            for (int k = 0; k < TAPS; k++) r_x[k] <= '0;
            r_acc  <= '0;
            r_tap  <= '0;
            r_warm <= '0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    r_x[0] <= r_in_mem[r_in_rp];
                    for (int k = 1; k < TAPS; k++) r_x[k] <= r_x[k-1];
                    r_acc <= '0;
                    r_tap <= '0;
                    if (r_warm < WARM_FULL) r_warm <= r_warm + WCW'(1);
                end
                S_MAC: begin
                    r_acc <= r_acc + w_prod;
                    r_tap <= r_tap + TW'(1);
                end
                default: ;
            endcase
        end
    end

    // ---------------- outputs ----------------
    assign wbs_ack_o      = r_ack;
    assign wbs_dat_o      = r_dat;
    assign busy_flag      = w_busy;
    assign in_full_flag   = w_in_full;
    assign out_valid_flag = ~w_out_empty;
    assign err_flag       = r_ovf | r_unf | r_cfg_err;
    assign irq_o          = r_irq_en & ~w_out_empty;

endmodule
